overdrive_ctrl: RTL and testbench

OVERDRIVE_CTRL -- requirements
Module: overdrive_ctrl

---
 rtl/overdrive_pkg.sv | 14 +
 rtl/overdrive_ctrl.sv | 96 +++++++++
 tb/tb_overdrive_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/overdrive_pkg.sv
// Shared types and constants for the overdrive threshold controller.
// Holds the FSM state encoding and default ramp parameters.
package overdrive_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } od_state_e;

    localparam int THR_MIN       = 1;
    localparam int STEP_DEF      = 4;
    localparam int THR_RESET_DEF = 100;

endpackage

// File: rtl/overdrive_ctrl.sv
// Overdrive threshold controller: accepts threshold/bypass requests
// and slews the clipper threshold toward the target once per frame.
module overdrive_ctrl
    import overdrive_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int STEP       = STEP_DEF,
    parameter int THR_RESET  = THR_RESET_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_threshold,
    input  logic                  cfg_bypass,
    output logic [DATA_WIDTH-1:0] threshold_out,
    output logic                  bypass_out,
    output logic                  busy
);

    localparam logic [DATA_WIDTH-1:0] LP_THR_RST = DATA_WIDTH'(THR_RESET);
    localparam logic [DATA_WIDTH-1:0] LP_THR_MIN = DATA_WIDTH'(THR_MIN);
    localparam logic [DATA_WIDTH-1:0] LP_STEP    = DATA_WIDTH'(STEP);
    localparam logic [DATA_WIDTH:0]   LP_STEP_X  = (DATA_WIDTH+1)'(STEP);

    od_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_target;
    logic [DATA_WIDTH-1:0] r_thr;
    logic                  r_byp;
    logic                  r_byp_req;
    logic                  r_byp_pend;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_clamp;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH:0]   w_mag;
    logic                  w_near;

    assign cfg_ready     = (r_state == ST_IDLE);
    assign threshold_out = r_thr;
    assign bypass_out    = r_byp;
    assign busy          = (r_state == ST_RAMP) | r_byp_pend;

    assign w_accept = cfg_valid & cfg_ready;

    // Requests below the minimum clamp to 1; the signed maximum is
    // already the natural upper bound of the field.
    always_comb begin
        w_clamp = cfg_threshold;
        if ($signed(cfg_threshold) < $signed(LP_THR_MIN)) begin
            w_clamp = LP_THR_MIN;
        end
    end

    // Signed distance to target, one bit wider so it cannot overflow.
    always_comb begin
        w_diff = {r_target[DATA_WIDTH-1], r_target}
               - {r_thr[DATA_WIDTH-1], r_thr};
        w_mag  = w_diff[DATA_WIDTH] ? (~w_diff + 1'b1) : w_diff;
        w_near = (w_mag <= LP_STEP_X);
    end

    // Request acceptance, per-tick ramp stepping and bypass update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_target   <= LP_THR_RST;
            r_thr      <= LP_THR_RST;
            r_byp      <= 1'b0;
            r_byp_req  <= 1'b0;
            r_byp_pend <= 1'b0;
        end else if (w_accept) begin
            r_target   <= w_clamp;
            r_byp_req  <= cfg_bypass;
            r_byp_pend <= (cfg_bypass != r_byp);
            r_state    <= (w_clamp != r_thr) ? ST_RAMP : ST_IDLE;
        end else if (sample_tick) begin
            if (r_byp_pend) begin
                r_byp      <= r_byp_req;
                r_byp_pend <= 1'b0;
            end
            if (r_state == ST_RAMP) begin
                if (w_near) begin
                    r_thr   <= r_target;
                    r_state <= ST_IDLE;
                end else if (w_diff[DATA_WIDTH]) begin
                    r_thr <= r_thr - LP_STEP;
                end else begin
                    r_thr <= r_thr + LP_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_overdrive_ctrl.sv
// Self-checking bench for overdrive_ctrl.
// Table vectors plus hand sequences, checked through an expectation queue.
module tb_overdrive_ctrl;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sample_tick;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_threshold;
    logic         cfg_bypass;
    logic [W-1:0] threshold_out;
    logic         bypass_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [W-1:0] thr;
        logic         byp;
        logic         bsy;
        logic         rdy;
    } exp_t;

    typedef struct {
        logic         v;
        logic [W-1:0] t;
        logic         b;
        logic         k;
        logic [W-1:0] et;
        logic         eb;
        logic         ebz;
        logic         er;
    } vec_t;

    exp_t q[$];
    vec_t tbl[6];

    overdrive_ctrl #(
        .DATA_WIDTH(W),
        .STEP(4),
        .THR_RESET(100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_threshold(cfg_threshold),
        .cfg_bypass   (cfg_bypass),
        .threshold_out(threshold_out),
        .bypass_out   (bypass_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [W-1:0] t, input logic b,
                        input logic z, input logic r);
        exp_t e;
        e.thr = t;
        e.byp = b;
        e.bsy = z;
        e.rdy = r;
        q.push_back(e);
    endtask

    task automatic check(input string name);
        exp_t e;
        exp_t a;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = q.pop_front();
            a = {threshold_out, bypass_out, busy, cfg_ready};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got thr=%0d byp=%b busy=%b rdy=%b, want thr=%0d byp=%b busy=%b rdy=%b",
                         name, a.thr, a.byp, a.bsy, a.rdy,
                         e.thr, e.byp, e.bsy, e.rdy);
            end
        end
    endtask

    // One clock: drive at negedge, compare just after the rising edge.
    task automatic cyc(input logic v, input logic [W-1:0] t,
                       input logic b, input logic k,
                       input logic [W-1:0] et, input logic eb,
                       input logic ez, input logic er,
                       input string name);
        @(negedge clk);
        cfg_valid     = v;
        cfg_threshold = t;
        cfg_bypass    = b;
        sample_tick   = k;
        push(et, eb, ez, er);
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        cfg_valid     = 1'b0;
        cfg_threshold = '0;
        cfg_bypass    = 1'b0;
        sample_tick   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        push(24'd100, 1'b0, 1'b0, 1'b1);
        check("reset");
    endtask

    initial begin
        logic [W-1:0] neg5;
        logic [W-1:0] exp_thr;
        neg5 = 24'hFFFFFB;

        tbl[0] = '{1'b1, 24'd110, 1'b0, 1'b0, 24'd100, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 24'd0,   1'b0, 1'b0, 24'd100, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 24'd0,   1'b0, 1'b1, 24'd104, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 24'd0,   1'b0, 1'b0, 24'd104, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 24'd0,   1'b0, 1'b1, 24'd108, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 24'd0,   1'b0, 1'b1, 24'd110, 1'b0, 1'b0, 1'b1};

        rst_n         = 1'b0;
        cfg_valid     = 1'b0;
        cfg_threshold = '0;
        cfg_bypass    = 1'b0;
        sample_tick   = 1'b0;

        do_reset();

        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].v, tbl[i].t, tbl[i].b, tbl[i].k,
                tbl[i].et, tbl[i].eb, tbl[i].ebz, tbl[i].er,
                $sformatf("up_ramp[%0d]", i));
        end

        // Down-ramp with clamp: -5 -> 1, 24 steps of 4 then one of 3.
        do_reset();
        cyc(1'b1, neg5, 1'b0, 1'b0, 24'd100, 1'b0, 1'b1, 1'b0, "down_acc");
        for (int k = 1; k <= 24; k++) begin
            exp_thr = 24'(100 - 4 * k);
            cyc(1'b0, '0, 1'b0, 1'b1, exp_thr, 1'b0, 1'b1, 1'b0,
                $sformatf("down_step%0d", k));
        end
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd1, 1'b0, 1'b0, 1'b1, "down_last");
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd1, 1'b0, 1'b0, 1'b1, "down_hold");

        // Acceptance coincident with a tick: no step on that tick.
        do_reset();
        cyc(1'b1, 24'd120, 1'b0, 1'b1, 24'd100, 1'b0, 1'b1, 1'b0, "acc_tick");
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd104, 1'b0, 1'b1, 1'b0, "acc_tick_s1");
        for (int k = 2; k <= 5; k++) begin
            exp_thr = 24'(100 + 4 * k);
            cyc(1'b0, '0, 1'b0, 1'b1, exp_thr, 1'b0, (k != 5), (k == 5),
                $sformatf("acc_tick_s%0d", k));
        end

        // Bypass with equal threshold: applied only on the next tick.
        cyc(1'b1, 24'd120, 1'b1, 1'b0, 24'd120, 1'b0, 1'b1, 1'b1, "byp_acc");
        cyc(1'b0, '0, 1'b0, 1'b0, 24'd120, 1'b0, 1'b1, 1'b1, "byp_wait");
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd120, 1'b1, 1'b0, 1'b1, "byp_tick");

        // Back-pressure: second request held through the ramp.
        cyc(1'b1, 24'd128, 1'b1, 1'b0, 24'd120, 1'b1, 1'b1, 1'b0, "bp_acc");
        cyc(1'b1, 24'd200, 1'b0, 1'b0, 24'd120, 1'b1, 1'b1, 1'b0, "bp_hold0");
        cyc(1'b1, 24'd200, 1'b0, 1'b1, 24'd124, 1'b1, 1'b1, 1'b0, "bp_hold1");
        cyc(1'b1, 24'd200, 1'b0, 1'b1, 24'd128, 1'b1, 1'b0, 1'b1, "bp_done");
        cyc(1'b1, 24'd200, 1'b0, 1'b0, 24'd128, 1'b1, 1'b1, 1'b0, "bp_acc2");
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd132, 1'b0, 1'b1, 1'b0, "bp_step");

        // Reset mid-ramp at 108: immediate return, no target kept.
        do_reset();
        cyc(1'b1, 24'd110, 1'b0, 1'b0, 24'd100, 1'b0, 1'b1, 1'b0, "mid_acc");
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd104, 1'b0, 1'b1, 1'b0, "mid_s1");
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd108, 1'b0, 1'b1, 1'b0, "mid_s2");
        @(negedge clk);
        sample_tick = 1'b0;
        rst_n       = 1'b0;
        #1;
        push(24'd100, 1'b0, 1'b0, 1'b1);
        check("mid_async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd100, 1'b0, 1'b0, 1'b1, "post_rst_t1");
        cyc(1'b0, '0, 1'b0, 1'b1, 24'd100, 1'b0, 1'b0, 1'b1, "post_rst_t2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

endmodule
